mem_port_arbiter: RTL and testbench

- Shares the processor's single memory port between three requesters: instruction fetch (id 0), data load/store (id 1) and stack push/pop/call/ret (id 2).
- Sits between the multicycle controller/datapath and the memory.
- Each requester issues one request and waits for a done pulse; every transaction is a fixed-latency access; requesters are arbitrated round-robin.

---
 rtl/mem_port_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one fixed-latency memory port between fetch (0),
// data (1) and stack (2) requesters; one transaction in flight at a time.
module mem_port_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int MEM_LAT = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [2:0]            req,
  input  logic [2:0]            we,
  input  logic [3*ADDR_W-1:0]   addr,
  input  logic [3*DATA_W-1:0]   wdata,
  output logic [2:0]            gnt,
  output logic [2:0]            done,
  output logic [DATA_W-1:0]     rdata,
  output logic                  busy,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic                  mem_read,
  output logic                  mem_write,
  input  logic [DATA_W-1:0]     mem_rdata
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;

  // An illegal zero latency is treated as a single access cycle.
  localparam logic [3:0] LAT = (MEM_LAT < 1) ? 4'd1 : 4'(MEM_LAT);

  logic [1:0]        stateR;
  logic [1:0]        ptrR;
  logic [1:0]        idR;
  logic [3:0]        cntR;
  logic [1:0]        winId;
  logic              winValid;
  logic              winWe;
  logic [ADDR_W-1:0] winAddr;
  logic [DATA_W-1:0] winWdata;
  logic [1:0]        nextPtr;

  function automatic logic [2:0] oneHot(input logic [1:0] id);
    case (id)
      2'd0:    oneHot = 3'b001;
      2'd1:    oneHot = 3'b010;
      2'd2:    oneHot = 3'b100;
      default: oneHot = 3'b000;
    endcase
  endfunction

  // Round-robin winner: first set req bit scanning from ptrR upward, modulo 3.
  always_comb begin
    winId    = 2'd0;
    winValid = |req;
    case (ptrR)
      2'd1: begin
        if (req[1])      winId = 2'd1;
        else if (req[2]) winId = 2'd2;
        else             winId = 2'd0;
      end
      2'd2: begin
        if (req[2])      winId = 2'd2;
        else if (req[0]) winId = 2'd0;
        else             winId = 2'd1;
      end
      default: begin
        if (req[0])      winId = 2'd0;
        else if (req[1]) winId = 2'd1;
        else             winId = 2'd2;
      end
    endcase
  end

  // Select the winner's request fields; other slices never reach the port.
  always_comb begin
    winWe    = 1'b0;
    winAddr  = {ADDR_W{1'b0}};
    winWdata = {DATA_W{1'b0}};
    case (winId)
      2'd0: begin
        winWe    = we[0];
        winAddr  = addr[0 +: ADDR_W];
        winWdata = wdata[0 +: DATA_W];
      end
      2'd1: begin
        winWe    = we[1];
        winAddr  = addr[ADDR_W +: ADDR_W];
        winWdata = wdata[DATA_W +: DATA_W];
      end
      2'd2: begin
        winWe    = we[2];
        winAddr  = addr[2*ADDR_W +: ADDR_W];
        winWdata = wdata[2*DATA_W +: DATA_W];
      end
      default: begin
        winWe    = 1'b0;
        winAddr  = {ADDR_W{1'b0}};
        winWdata = {DATA_W{1'b0}};
      end
    endcase
  end

  // Pointer moves just past the requester that was served.
  always_comb begin
    case (idR)
      2'd0:    nextPtr = 2'd1;
      2'd1:    nextPtr = 2'd2;
      default: nextPtr = 2'd0;
    endcase
  end

  // Transaction sequencer: latch in IDLE, strobe for LAT cycles, then one RESP cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      stateR    <= IDLE;
      ptrR      <= 2'd0;
      idR       <= 2'd0;
      cntR      <= 4'd0;
      gnt       <= 3'b000;
      done      <= 3'b000;
      rdata     <= {DATA_W{1'b0}};
      busy      <= 1'b0;
      mem_addr  <= {ADDR_W{1'b0}};
      mem_wdata <= {DATA_W{1'b0}};
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
    end else begin
      case (stateR)
        IDLE: begin
          if (winValid) begin
            idR       <= winId;
            mem_addr  <= winAddr;
            mem_wdata <= winWdata;
            mem_read  <= ~winWe;
            mem_write <= winWe;
            gnt       <= oneHot(winId);
            busy      <= 1'b1;
            cntR      <= LAT;
            stateR    <= ACCESS;
          end else begin
            stateR    <= IDLE;
          end
        end
        ACCESS: begin
          cntR <= cntR - 4'd1;
          if (cntR == 4'd1) begin
            if (!mem_write) begin
              rdata <= mem_rdata;
            end else begin
              rdata <= rdata;
            end
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            done      <= gnt;
            stateR    <= RESP;
          end else begin
            stateR    <= ACCESS;
          end
        end
        RESP: begin
          done   <= 3'b000;
          gnt    <= 3'b000;
          busy   <= 1'b0;
          ptrR   <= nextPtr;
          stateR <= IDLE;
        end
        default: begin
          done      <= 3'b000;
          gnt       <= 3'b000;
          busy      <= 1'b0;
          mem_read  <= 1'b0;
          mem_write <= 1'b0;
          stateR    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios on a MEM_LAT=2 and a MEM_LAT=1
// instance, plus randomized traffic against a transaction-level reference model.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [2:0]  req, we;
  logic [47:0] addr, wdata;
  logic [2:0]  gnt2, done2, gnt1, done1;
  logic [15:0] rdata2, rdata1, memAddr2, memAddr1, memWdata2, memWdata1, memRdata2, memRdata1;
  logic        busy2, busy1, memRead2, memRead1, memWrite2, memWrite1;
  logic [15:0] memArr [256];

  assign memRdata2 = memArr[memAddr2[7:0]];
  assign memRdata1 = memArr[memAddr1[7:0]];

  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(2)) dut2 (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .gnt(gnt2), .done(done2), .rdata(rdata2), .busy(busy2),
    .mem_addr(memAddr2), .mem_wdata(memWdata2), .mem_read(memRead2),
    .mem_write(memWrite2), .mem_rdata(memRdata2));

  mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(1)) dut1 (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .gnt(gnt1), .done(done1), .rdata(rdata1), .busy(busy1),
    .mem_addr(memAddr1), .mem_wdata(memWdata1), .mem_read(memRead1),
    .mem_write(memWrite1), .mem_rdata(memRdata1));

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 3'b000; we = 3'b000; addr = 48'd0; wdata = 48'd0;
    repeat (3) tick();
    checks++;
    if ({gnt2, done2, busy2, memRead2, memWrite2, rdata2, memAddr2, memWdata2} !== 59'd0) begin
      errors++;
      $display("FAIL reset_lat2 got %h want 0", {gnt2, done2, busy2, memRead2, memWrite2, rdata2, memAddr2, memWdata2});
    end
    checks++;
    if ({gnt1, done1, busy1, memRead1, memWrite1, rdata1, memAddr1, memWdata1} !== 59'd0) begin
      errors++;
      $display("FAIL reset_lat1 got %h want 0", {gnt1, done1, busy1, memRead1, memWrite1, rdata1, memAddr1, memWdata1});
    end
    rst = 1'b0;
  endtask

  task automatic test_fetch_read();
    int readCyc = 0, busyCyc = 0, doneAt = -1;
    memArr[8'h40] = 16'h1234;
    req = 3'b001; we = 3'b000; addr[15:0] = 16'h0040;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (memRead2) begin
        readCyc++;
        checks++;
        if (memAddr2 !== 16'h0040) begin
          errors++; $display("FAIL fetch_addr got %h want 0040", memAddr2);
        end
      end
      if (busy2) busyCyc++;
      if (done2 !== 3'b000) begin
        if (doneAt < 0) doneAt = k;
        req = 3'b000;
        checks++;
        if ({done2, rdata2} !== {3'b001, 16'h1234}) begin
          errors++; $display("FAIL fetch_done got %h/%h want 1/1234", done2, rdata2);
        end
      end
    end
    checks++;
    if (readCyc !== 2) begin errors++; $display("FAIL fetch_read_cycles got %0d want 2", readCyc); end
    checks++;
    if (busyCyc !== 3) begin errors++; $display("FAIL fetch_busy_cycles got %0d want 3", busyCyc); end
    checks++;
    if (doneAt !== 3) begin errors++; $display("FAIL fetch_done_latency got %0d want 3", doneAt); end
  endtask

  task automatic test_stack_write();
    int writeCyc = 0, readCyc = 0, doneCnt = 0, doneAt = -1;
    req = 3'b100; we = 3'b100; addr[47:32] = 16'h7FFE; wdata[47:32] = 16'hBEEF;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (memRead2) readCyc++;
      if (memWrite2) begin
        writeCyc++;
        checks++;
        if ({memAddr2, memWdata2} !== {16'h7FFE, 16'hBEEF}) begin
          errors++; $display("FAIL write_port got %h/%h want 7ffe/beef", memAddr2, memWdata2);
        end
      end
      if (done2 !== 3'b000) begin
        doneCnt++;
        if (doneAt < 0) doneAt = k;
        req = 3'b000;
        checks++;
        if ({done2, rdata2} !== {3'b100, 16'h1234}) begin
          errors++; $display("FAIL write_done got %h/%h want 4/1234", done2, rdata2);
        end
      end
    end
    we = 3'b000;
    checks++;
    if ({writeCyc, readCyc, doneCnt, doneAt} !== {32'd2, 32'd0, 32'd1, 32'd3}) begin
      errors++; $display("FAIL write_counts got w%0d r%0d d%0d at%0d want w2 r0 d1 at3", writeCyc, readCyc, doneCnt, doneAt);
    end
  endtask

  task automatic test_all_three();
    int order[$];
    int at[$];
    int gntSeen;
    rst = 1'b1; req = 3'b111; we = 3'b000;
    addr = {16'h0003, 16'h0002, 16'h0001};
    tick(); tick();
    rst = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (done2 !== 3'b000) begin
        order.push_back(done2[0] ? 0 : (done2[1] ? 1 : 2));
        at.push_back(k);
        req = req & ~done2;
      end
    end
    checks++;
    if (order.size() !== 3) begin errors++; $display("FAIL rr_count got %0d want 3", order.size()); end
    for (int i = 0; i < order.size() && i < 3; i++) begin
      checks++;
      if (order[i] !== i) begin errors++; $display("FAIL rr_order[%0d] got %0d want %0d", i, order[i], i); end
      if (i > 0) begin
        checks++;
        if (at[i] - at[i-1] !== 4) begin errors++; $display("FAIL rr_spacing[%0d] got %0d want 4", i, at[i] - at[i-1]); end
      end
    end
    req = 3'b101;
    tick();
    gntSeen = int'(gnt2);
    checks++;
    if (gntSeen !== 1) begin errors++; $display("FAIL ptr_wrap got %0d want 1", gntSeen); end
    for (int k = 0; k < 12; k++) begin
      tick();
      req = req & ~done2;
    end
  endtask

  task automatic test_alternate();
    int seq[$];
    int served = 0, gotData = 0, raised = 0, id;
    req = 3'b101; we = 3'b000;
    for (int k = 1; k <= 60; k++) begin
      tick();
      if (done2 !== 3'b000 && gotData == 0) begin
        id = done2[0] ? 0 : (done2[1] ? 1 : 2);
        if (raised == 0) begin
          seq.push_back(id);
          if (seq.size() == 4) begin req[1] = 1'b1; raised = 1; end
        end else if (id == 1) begin
          gotData = 1;
          req = 3'b000;
        end else begin
          served++;
        end
      end
    end
    checks++;
    if (seq.size() !== 4) begin errors++; $display("FAIL alt_count got %0d want 4", seq.size()); end
    for (int i = 0; i < seq.size(); i++) begin
      checks++;
      if (seq[i] !== ((i % 2 == 0) ? 0 : 2)) begin
        errors++; $display("FAIL alt_seq[%0d] got %0d want %0d", i, seq[i], (i % 2 == 0) ? 0 : 2);
      end
    end
    checks++;
    if (gotData !== 1 || served > 2) begin
      errors++; $display("FAIL alt_fair got served=%0d data=%0d want data=1 served<=2", served, gotData);
    end
    req = 3'b000;
    tick(); tick();
  endtask

  task automatic test_reset_mid();
    int fetchDone = 0, dataDone = 0;
    memArr[8'h30] = 16'h3030; memArr[8'h50] = 16'h5050;
    req = 3'b010; we = 3'b000; addr[31:16] = 16'h0030;
    tick();
    req = 3'b011; addr[15:0] = 16'h0050;
    tick();
    checks++;
    if ({memRead2, gnt2} !== {1'b1, 3'b010}) begin
      errors++; $display("FAIL mid_access got %b/%b want 1/010", memRead2, gnt2);
    end
    rst = 1'b1;
    tick();
    checks++;
    if ({memRead2, gnt2, busy2, done2, rdata2} !== 24'd0) begin
      errors++; $display("FAIL mid_reset got %h want 0", {memRead2, gnt2, busy2, done2, rdata2});
    end
    rst = 1'b0;
    for (int k = 4; k <= 10; k++) begin
      tick();
      if (k == 4) begin
        checks++;
        if ({gnt2, memRead2, memAddr2} !== {3'b001, 1'b1, 16'h0050}) begin
          errors++; $display("FAIL mid_refetch got %b/%b/%h want 001/1/0050", gnt2, memRead2, memAddr2);
        end
      end
      if (done2[1]) dataDone++;
      if (done2[0]) begin
        fetchDone++;
        req = 3'b000;
        checks++;
        if (rdata2 !== 16'h5050) begin errors++; $display("FAIL mid_rdata got %h want 5050", rdata2); end
      end
    end
    checks++;
    if ({fetchDone, dataDone} !== {32'd1, 32'd0}) begin
      errors++; $display("FAIL mid_dones got fetch=%0d data=%0d want 1/0", fetchDone, dataDone);
    end
  endtask

  task automatic test_random();
    localparam int L = 2;
    int mBusy = 0, mPhase = 0, mId = 0, mPtr = 0;
    logic mWe = 1'b0;
    logic [15:0] mAddr = 16'd0, mWdata = 16'd0, mRdata = 16'd0;
    logic [2:0] eGnt, eDone;
    logic eBusy, eRd, eWr;
    int waitCnt[3] = '{0, 0, 0};
    int found, c;
    rst = 1'b1; req = 3'b000;
    tick(); tick();
    rst = 1'b0;
    for (int k = 0; k < 400; k++) begin
      tick();
      eGnt = 3'b000; eDone = 3'b000; eBusy = 1'b0; eRd = 1'b0; eWr = 1'b0;
      if (mBusy != 0) begin
        eGnt  = 3'b001 << mId;
        eBusy = 1'b1;
        if (mPhase <= L) begin eRd = ~mWe; eWr = mWe; end
        else eDone = 3'b001 << mId;
      end
      checks++;
      if ({gnt2, done2, busy2, memRead2, memWrite2, rdata2} !== {eGnt, eDone, eBusy, eRd, eWr, mRdata}) begin
        errors++;
        $display("FAIL rand_ctrl cyc %0d got %b %b %b %b %b %h want %b %b %b %b %b %h", k,
                 gnt2, done2, busy2, memRead2, memWrite2, rdata2, eGnt, eDone, eBusy, eRd, eWr, mRdata);
      end
      if (eRd || eWr) begin
        checks++;
        if (memAddr2 !== mAddr || (eWr && memWdata2 !== mWdata)) begin
          errors++; $display("FAIL rand_port cyc %0d got %h/%h want %h/%h", k, memAddr2, memWdata2, mAddr, mWdata);
        end
      end
      for (int i = 0; i < 3; i++) begin
        if (req[i] && done2 !== 3'b000 && !done2[i]) waitCnt[i]++;
        if (req[i] && done2[i]) begin
          checks++;
          if (waitCnt[i] > 2) begin errors++; $display("FAIL rand_fair req %0d got %0d want <=2", i, waitCnt[i]); end
          waitCnt[i] = 0;
        end
      end
      for (int i = 0; i < 3; i++) begin
        if ((req[i] && eDone[i] && ($urandom % 4 != 0 || k >= 370)) ) begin
          req[i] = 1'b0;
        end else if (req[i] && eDone[i]) begin
          we[i] = 1'($urandom); addr[i*16 +: 16] = 16'($urandom); wdata[i*16 +: 16] = 16'($urandom);
        end else if (!req[i] && k < 370 && $urandom % 3 == 0) begin
          req[i] = 1'b1; waitCnt[i] = 0;
          we[i] = 1'($urandom); addr[i*16 +: 16] = 16'($urandom); wdata[i*16 +: 16] = 16'($urandom);
        end
        if (!req[i]) begin
          we[i] = 1'($urandom); addr[i*16 +: 16] = 16'($urandom); wdata[i*16 +: 16] = 16'($urandom);
        end
      end
      if (mBusy != 0) begin
        if (mPhase == L && !mWe) mRdata = memArr[mAddr[7:0]];
        if (mPhase == L + 1) begin mBusy = 0; mPtr = (mId + 1) % 3; end
        else mPhase++;
      end else begin
        found = 0;
        for (int j = 0; j < 3; j++) begin
          c = (mPtr + j) % 3;
          if (found == 0 && req[c]) begin
            found = 1; mId = c; mWe = we[c];
            mAddr = addr[c*16 +: 16]; mWdata = wdata[c*16 +: 16];
            mBusy = 1; mPhase = 1;
          end
        end
      end
    end
    req = 3'b000; we = 3'b000;
  endtask

  task automatic test_lat1();
    int n = 0, readCyc = 0;
    int at[2] = '{0, 0};
    rst = 1'b1; req = 3'b000;
    tick(); tick();
    rst = 1'b0;
    memArr[8'h10] = 16'hA001; memArr[8'h11] = 16'hA002;
    req = 3'b010; we = 3'b000; addr[31:16] = 16'h0010;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (memRead1) begin
        readCyc++;
        checks++;
        if (memAddr1 !== ((n == 0) ? 16'h0010 : 16'h0011)) begin
          errors++; $display("FAIL lat1_addr got %h want %h", memAddr1, (n == 0) ? 16'h0010 : 16'h0011);
        end
      end
      if (done1 !== 3'b000 && n < 2) begin
        at[n] = k;
        checks++;
        if ({done1, rdata1} !== {3'b010, ((n == 0) ? 16'hA001 : 16'hA002)}) begin
          errors++; $display("FAIL lat1_done[%0d] got %b/%h want 010/%h", n, done1, rdata1, (n == 0) ? 16'hA001 : 16'hA002);
        end
        if (n == 0) addr[31:16] = 16'h0011;
        else req = 3'b000;
        n++;
      end
    end
    checks++;
    if ({n, readCyc, at[0], at[1]} !== {32'd2, 32'd2, 32'd2, 32'd5}) begin
      errors++; $display("FAIL lat1_timing got n%0d r%0d at%0d/%0d want n2 r2 at2/5", n, readCyc, at[0], at[1]);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) memArr[i] = 16'($urandom);
    test_reset();
    test_fetch_read();
    test_stack_write();
    test_all_three();
    test_alternate();
    test_reset_mid();
    test_random();
    test_lat1();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
